// File: rtl/dtw_accel_query_loader.sv
// Streams QUERY_LEN offset-binary samples from a FIFO into the query buffer and then kicks the DTW core.
// One write per pop, one cycle after it; stalls without timeout while the FIFO is empty.
module dtw_accel_query_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int QUERY_LEN  = 250,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic                             load_start,
  input  logic                             abort,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  input  logic                             fifo_empty,
  output logic                             fifo_rden,
  output logic                             q_wr_en,
  output logic [ADDR_WIDTH-1:0]            q_wr_addr,
  output logic [DATA_WIDTH-1:0]            q_wr_data,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] q_sum,
  output logic                             dtw_start,
  input  logic                             dtw_done,
  output logic                             busy,
  output logic                             done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int SW = DATA_WIDTH + ADDR_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [CW-1:0] LEN      = CW'(QUERY_LEN);
  localparam logic [CW-1:0] LEN_M1   = CW'(QUERY_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                  pop;
  logic [DATA_WIDTH-1:0] conv;
  logic [SW-1:0]         conv_ext;

  // count holds 0..QUERY_LEN, so it is one bit wider than the buffer address
  assign pop       = (state_q == S_LOAD) && !fifo_empty && (count_q < LEN);
  assign fifo_rden = pop;

  assign conv     = {~fifo_dout[DATA_WIDTH-1], fifo_dout[DATA_WIDTH-2:0]};
  assign conv_ext = {{ADDR_WIDTH{conv[DATA_WIDTH-1]}}, conv};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // abort wins: a sample popped in the abort cycle is dropped, and count/sum keep their values
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_d = S_LOAD;
            count_d = '0;
            sum_d   = '0;
          end
        end
        S_LOAD: begin
          if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q[ADDR_WIDTH-1:0];
            wr_data_d = conv;
            sum_d     = sum_q + conv_ext;
            count_d   = count_q + CNT_ONE;
            if (count_q == LEN_M1) begin
              state_d = S_FLUSH;
            end
          end
        end
        S_FLUSH: state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT: begin
          if (dtw_done) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign q_wr_en   = wr_en_q;
  assign q_wr_addr = wr_addr_q;
  assign q_wr_data = wr_data_q;
  assign q_sum     = sum_q;
  assign dtw_start = (state_q == S_START) && !abort;
  assign done      = (state_q == S_WAIT) && dtw_done && !abort;
  assign busy      = (state_q != S_IDLE);

endmodule
